router_reg: RTL and testbench

- Datapath register stage that sits directly downstream of the router FSM and upstream of the three output FIFOs.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header, drives the byte written into the selected FIFO (dout), and holds a byte across FIFO-full stalls.
- Accumulates running parity and reports parity_done, low_pkt_valid and err back to the FSM and host.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_parity_acc.sv | 94 +++++++++
 rtl/router_reg.sv | 99 +++++++++
 tb/tb_router_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants, header field positions and FSM state encodings.
// Imported by the register stage, its parity accumulator and the benches.
package router_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;

    localparam logic [1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    function automatic logic is_valid_addr(input logic [1:0] addr);
        return addr != INVALID_ADDR;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running parity, received parity, parity_done and one-shot err evaluation.
// err is judged once per packet, the edge after parity_done first rises.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] header,
    input  logic                  pkt_valid,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  low_pkt_valid,
    output logic                  parity_done,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
    logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
    logic                  done_q, done_d;
    logic                  eval_q, eval_d;
    logic                  err_q, err_d;
    logic                  eval_now;

    assign eval_now = done_q && !eval_q;

    // Next-state for parity accumulation, completion and error flag.
    always_comb begin
        int_parity_d = int_parity_q;
        pkt_parity_d = pkt_parity_q;
        done_d       = done_q;
        eval_d       = eval_q;
        err_d        = err_q;

        if (detect_add) begin
            int_parity_d = '0;
            pkt_parity_d = '0;
        end else if (lfd_state) begin
            int_parity_d = int_parity_q ^ header;
        end else if (ld_state) begin
            if (pkt_valid) begin
                int_parity_d = int_parity_q ^ data_in;
            end else begin
                pkt_parity_d = data_in;
            end
        end

        if (ld_state && !pkt_valid && !fifo_full) begin
            done_d = 1'b1;
        end else if (laf_state && low_pkt_valid && !done_q) begin
            done_d = 1'b1;
        end else if (detect_add) begin
            done_d = 1'b0;
        end

        if (detect_add) begin
            eval_d = 1'b0;
        end else if (eval_now) begin
            eval_d = 1'b1;
        end

        if (detect_add && pkt_valid) begin
            err_d = 1'b0;
        end else if (eval_now) begin
            err_d = (int_parity_q != pkt_parity_q);
        end
    end

    // Parity state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_parity_q <= '0;
            pkt_parity_q <= '0;
            done_q       <= 1'b0;
            eval_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            int_parity_q <= int_parity_d;
            pkt_parity_q <= pkt_parity_d;
            done_q       <= done_d;
            eval_q       <= eval_d;
            err_q        <= err_d;
        end
    end

    assign parity_done = done_q;
    assign err         = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register: header latch, FIFO write byte and stall hold.
// Bytes stalled by a full FIFO are parked in hold_q and replayed once.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pkt_valid,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] header_q, header_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  lpv_q, lpv_d;
    logic                  hdr_ok;

    assign hdr_ok = is_valid_addr(data_in[ADDR_MSB:ADDR_LSB]);

    // Next-state for header, hold byte, output byte and low_pkt_valid.
    always_comb begin
        header_d = header_q;
        hold_d   = hold_q;
        dout_d   = dout_q;
        lpv_d    = lpv_q;

        if (detect_add && pkt_valid && hdr_ok) begin
            header_d = data_in;
        end

        if (lfd_state) begin
            dout_d = header_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            hold_d = data_in;
        end else if (laf_state) begin
            dout_d = hold_q;
        end else if (full_state) begin
            dout_d = dout_q;
        end

        if (ld_state && !pkt_valid) begin
            lpv_d = 1'b1;
        end else if (rst_int_reg || detect_add) begin
            lpv_d = 1'b0;
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            header_q <= '0;
            hold_q   <= '0;
            dout_q   <= '0;
            lpv_q    <= 1'b0;
        end else begin
            header_q <= header_d;
            hold_q   <= hold_d;
            dout_q   <= dout_d;
            lpv_q    <= lpv_d;
        end
    end

    router_parity_acc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .header       (header_q),
        .pkt_valid    (pkt_valid),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .low_pkt_valid(lpv_q),
        .parity_done  (parity_done),
        .err          (err)
    );

    assign dout          = dout_q;
    assign low_pkt_valid = lpv_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed, table-driven bench for router_reg.
// Each vector drives one FSM state and checks outputs after that edge.
module tb_router_reg;
    import router_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int checks;
    int errors;

    typedef struct {
        router_state_e st;
        logic [7:0]    d;
        logic          pv;
        logic          ff;
        logic [7:0]    e_dout;
        logic          e_pd;
        logic          e_lpv;
        logic          e_err;
    } vec_t;

    vec_t vq[$];

    router_reg #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .pkt_valid    (pkt_valid),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input router_state_e st, input logic [7:0] d,
                         input logic pv, input logic ff);
        detect_add  = (st == DECODE_ADDRESS);
        lfd_state   = (st == LOAD_FIRST_DATA);
        ld_state    = (st == LOAD_DATA);
        laf_state   = (st == LOAD_AFTER_FULL);
        full_state  = (st == FIFO_FULL_STATE);
        rst_int_reg = (st == CHECK_PARITY_ERROR);
        data_in     = d;
        pkt_valid   = pv;
        fifo_full   = ff;
    endtask

    task automatic step(input router_state_e st, input logic [7:0] d,
                        input logic pv, input logic ff);
        drive(st, d, pv, ff);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input router_state_e st, input logic [7:0] d,
                       input logic pv, input logic ff,
                       input logic [7:0] ed, input logic epd,
                       input logic elpv, input logic eerr);
        vec_t v;
        v.st = st; v.d = d; v.pv = pv; v.ff = ff;
        v.e_dout = ed; v.e_pd = epd; v.e_lpv = elpv; v.e_err = eerr;
        vq.push_back(v);
    endtask

    task automatic run_vec(input int i);
        step(vq[i].st, vq[i].d, vq[i].pv, vq[i].ff);
        chk($sformatf("v%0d_dout", i), dout, vq[i].e_dout);
        chk($sformatf("v%0d_pd", i), {7'd0, parity_done}, {7'd0, vq[i].e_pd});
        chk($sformatf("v%0d_lpv", i), {7'd0, low_pkt_valid}, {7'd0, vq[i].e_lpv});
        chk($sformatf("v%0d_err", i), {7'd0, err}, {7'd0, vq[i].e_err});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(WAIT_TILL_EMPTY, 8'h00, 1'b0, 1'b0);

        // clean packet, from reset (indices 0..7)
        add(DECODE_ADDRESS,     8'h0D, 1, 0, 8'h00, 0, 0, 0);
        add(LOAD_FIRST_DATA,    8'h00, 1, 0, 8'h0D, 0, 0, 0);
        add(LOAD_DATA,          8'h11, 1, 0, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          8'h22, 1, 0, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          8'h33, 1, 0, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          8'h0D, 0, 0, 8'h0D, 1, 1, 0);
        add(LOAD_PARITY,        8'h00, 0, 0, 8'h0D, 1, 1, 0);
        add(CHECK_PARITY_ERROR, 8'h00, 0, 0, 8'h0D, 1, 0, 0);
        // bad parity
        add(DECODE_ADDRESS,     8'h0D, 1, 0, 8'h0D, 0, 0, 0);
        add(LOAD_FIRST_DATA,    8'h00, 1, 0, 8'h0D, 0, 0, 0);
        add(LOAD_DATA,          8'h11, 1, 0, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          8'h22, 1, 0, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          8'h33, 1, 0, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          8'h0E, 0, 0, 8'h0E, 1, 1, 0);
        add(LOAD_PARITY,        8'h00, 0, 0, 8'h0E, 1, 1, 1);
        add(CHECK_PARITY_ERROR, 8'h00, 0, 0, 8'h0E, 1, 0, 1);
        add(DECODE_ADDRESS,     8'h00, 0, 0, 8'h0E, 0, 0, 1);
        add(DECODE_ADDRESS,     8'h0D, 1, 0, 8'h0E, 0, 0, 0);
        // mid-packet stall
        add(LOAD_FIRST_DATA,    8'h00, 1, 0, 8'h0D, 0, 0, 0);
        add(LOAD_DATA,          8'h11, 1, 0, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          8'h22, 1, 1, 8'h11, 0, 0, 0);
        add(FIFO_FULL_STATE,    8'h00, 1, 1, 8'h11, 0, 0, 0);
        add(FIFO_FULL_STATE,    8'h00, 1, 1, 8'h11, 0, 0, 0);
        add(FIFO_FULL_STATE,    8'h00, 1, 1, 8'h11, 0, 0, 0);
        add(LOAD_AFTER_FULL,    8'h00, 1, 0, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          8'h33, 1, 0, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          8'h0D, 0, 0, 8'h0D, 1, 1, 0);
        add(LOAD_PARITY,        8'h00, 0, 0, 8'h0D, 1, 1, 0);
        add(CHECK_PARITY_ERROR, 8'h00, 0, 0, 8'h0D, 1, 0, 0);
        // stalled parity byte, exit straight from load_after_full
        add(DECODE_ADDRESS,     8'h0D, 1, 0, 8'h0D, 0, 0, 0);
        add(LOAD_FIRST_DATA,    8'h00, 1, 0, 8'h0D, 0, 0, 0);
        add(LOAD_DATA,          8'h11, 1, 0, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          8'h22, 1, 0, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          8'h33, 1, 0, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          8'h0D, 0, 1, 8'h33, 0, 1, 0);
        add(FIFO_FULL_STATE,    8'h00, 0, 1, 8'h33, 0, 1, 0);
        add(LOAD_AFTER_FULL,    8'h00, 0, 0, 8'h0D, 1, 1, 0);
        add(WAIT_TILL_EMPTY,    8'h00, 0, 0, 8'h0D, 1, 1, 0);
        // invalid address keeps the previous header
        add(DECODE_ADDRESS,     8'h06, 1, 0, 8'h0D, 0, 0, 0);
        add(LOAD_FIRST_DATA,    8'h00, 1, 0, 8'h06, 0, 0, 0);
        add(DECODE_ADDRESS,     8'h0F, 1, 0, 8'h06, 0, 0, 0);
        add(LOAD_FIRST_DATA,    8'h00, 1, 0, 8'h06, 0, 0, 0);

        #22;
        chk("rst_dout", dout, 8'h00);
        chk("rst_pd", {7'd0, parity_done}, 8'h00);
        chk("rst_lpv", {7'd0, low_pkt_valid}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(i);
        end

        // drive a bad packet to its error state, then reset between edges
        step(DECODE_ADDRESS, 8'h0D, 1, 0);
        step(LOAD_FIRST_DATA, 8'h00, 1, 0);
        step(LOAD_DATA, 8'h11, 1, 0);
        step(LOAD_DATA, 8'h22, 1, 0);
        step(LOAD_DATA, 8'h33, 1, 0);
        step(LOAD_DATA, 8'h0E, 0, 0);
        step(LOAD_PARITY, 8'h00, 0, 0);
        chk("pre_dout", dout, 8'h0E);
        chk("pre_pd", {7'd0, parity_done}, 8'h01);
        chk("pre_lpv", {7'd0, low_pkt_valid}, 8'h01);
        chk("pre_err", {7'd0, err}, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_pd", {7'd0, parity_done}, 8'h00);
        chk("arst_lpv", {7'd0, low_pkt_valid}, 8'h00);
        chk("arst_err", {7'd0, err}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
